// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter that serialises ATM terminal commands onto a shared account ledger.
// Each granted command is checked in EXEC and applied on the edge that leaves COMMIT.
module atm_ledger_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_ACC  = 10,
  parameter int INIT_BAL = 500,
  parameter int MAX_BAL  = 2047
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   op,
  input  logic [4*NUM_REQ-1:0]   src_idx,
  input  logic [4*NUM_REQ-1:0]   dst_idx,
  input  logic [11*NUM_REQ-1:0]  amount,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [15:0]            rsp_balance
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_BAL  = 2'd0;
  localparam logic [1:0] OP_WD   = 2'd1;
  localparam logic [1:0] OP_XFER = 2'd2;

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         rsp_q, rsp_d;
  logic [1:0]          op_q, op_d;
  logic [3:0]          src_q, src_d;
  logic [3:0]          dst_q, dst_d;
  logic [10:0]         amt_q, amt_d;
  logic                ok_q, ok_d;
  logic [15:0]         bal_q [NUM_ACC];
  logic [15:0]         bal_d [NUM_ACC];

  logic                found;
  logic [IW-1:0]       winIdx;
  logic [IW-1:0]       cand;
  logic [15:0]         srcBal, dstBal, srcNew, dstNew;
  logic [16:0]         dstSum;
  logic                srcOk, dstOk, amtFits, dstFits, okC;

  // Search begins at the pointer, so the terminal after the last winner has top priority.
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winIdx = cand;
      end
    end
  end

  always_comb begin
    srcBal = '0;
    dstBal = '0;
    for (int a = 0; a < NUM_ACC; a++) begin
      if (src_q == 4'(a)) srcBal = bal_q[a];
      if (dst_q == 4'(a)) dstBal = bal_q[a];
    end
    srcOk   = int'(src_q) < NUM_ACC;
    dstOk   = int'(dst_q) < NUM_ACC;
    amtFits = {5'b0, amt_q} <= srcBal;
    dstSum  = {1'b0, dstBal} + {6'b0, amt_q};
    dstFits = dstSum <= 17'(MAX_BAL);
    srcNew  = srcBal - {5'b0, amt_q};
    dstNew  = dstSum[15:0];
    case (op_q)
      OP_BAL:  okC = srcOk;
      OP_WD:   okC = srcOk && amtFits;
      OP_XFER: okC = srcOk && dstOk && (src_q != dst_q) && amtFits && dstFits;
      default: okC = 1'b0;
    endcase
  end

  // Next-state, command latch and ledger update; the ledger is only written leaving COMMIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    rsp_d   = '0;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    amt_d   = amt_q;
    ok_d    = ok_q;
    bal_d   = bal_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          for (int t = 0; t < NUM_REQ; t++) begin
            if (winIdx == IW'(t)) begin
              gnt_d[t] = 1'b1;
              op_d     = op[2*t +: 2];
              src_d    = src_idx[4*t +: 4];
              dst_d    = dst_idx[4*t +: 4];
              amt_d    = amount[11*t +: 11];
            end
          end
          ptr_d   = IW'((int'(winIdx) + 1) % NUM_REQ);
          state_d = EXEC;
        end
      end
      EXEC: begin
        ok_d    = okC;
        state_d = COMMIT;
      end
      COMMIT: begin
        done_d  = gnt_q;
        err_d   = !ok_q;
        rsp_d   = (ok_q && op_q != OP_BAL) ? srcNew : srcBal;
        state_d = IDLE;
        if (ok_q && (op_q == OP_WD || op_q == OP_XFER)) begin
          for (int a = 0; a < NUM_ACC; a++) begin
            if (src_q == 4'(a)) bal_d[a] = srcNew;
            if (op_q == OP_XFER && dst_q == 4'(a)) bal_d[a] = dstNew;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      amt_q   <= '0;
      ok_q    <= 1'b0;
      for (int a = 0; a < NUM_ACC; a++) bal_q[a] <= 16'(INIT_BAL);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      amt_q   <= amt_d;
      ok_q    <= ok_d;
      for (int a = 0; a < NUM_ACC; a++) bal_q[a] <= bal_d[a];
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rsp_balance = rsp_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed bench for atm_ledger_arbiter; expected responses are queued at issue time
// and popped when the granted terminal sees its done pulse.
module tb_atm_ledger_arbiter;

  localparam logic [1:0] OP_BAL  = 2'd0;
  localparam logic [1:0] OP_WD   = 2'd1;
  localparam logic [1:0] OP_XFER = 2'd2;
  localparam logic [1:0] OP_RSV  = 2'd3;

  typedef struct {
    int          term;
    logic        err;
    logic [15:0] bal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [15:0] srcIdx;
  logic [15:0] dstIdx;
  logic [43:0] amount;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [15:0] rspBalance;

  exp_t expQ[$];
  int   checkCount = 0;
  int   failCount  = 0;

  atm_ledger_arbiter #(
    .NUM_REQ(4), .NUM_ACC(10), .INIT_BAL(500), .MAX_BAL(2047)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .op(op),
    .src_idx(srcIdx),
    .dst_idx(dstIdx),
    .amount(amount),
    .gnt(gnt),
    .done(done),
    .err(err),
    .rsp_balance(rspBalance)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int term, input logic [1:0] opc, input logic [3:0] s,
                               input logic [3:0] d, input logic [10:0] amt,
                               input logic expErr, input logic [15:0] expBal, input bit push);
    op[2*term +: 2]      = opc;
    srcIdx[4*term +: 4]  = s;
    dstIdx[4*term +: 4]  = d;
    amount[11*term +: 11] = amt;
    req[term]            = 1'b1;
    if (push) expQ.push_back('{term, expErr, expBal});
  endtask

  // Grant, then scramble the command inputs to prove they were latched, then await done.
  task automatic runOp(input int term);
    int   cycles;
    exp_t e;
    @(posedge clk); #1;
    checkOutput("gnt", 32'(gnt), 32'(1 << term));
    req    = '0;
    op     = 8'($urandom);
    srcIdx = 16'($urandom);
    dstIdx = 16'($urandom);
    amount = 44'({$urandom, $urandom});
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (done == '0 && cycles < 6);
    checkOutput("doneLatency", 32'(cycles), 32'd2);
    e = expQ.pop_front();
    checkOutput("doneTerm", 32'(done), 32'(1 << e.term));
    checkOutput("err", 32'(err), 32'(e.err));
    checkOutput("rspBalance", 32'(rspBalance), 32'(e.bal));
    @(posedge clk); #1;
    checkOutput("gntRelease", 32'(gnt), 32'd0);
    checkOutput("donePulse", 32'(done), 32'd0);
  endtask

  task automatic doOp(input int term, input logic [1:0] opc, input logic [3:0] s,
                      input logic [3:0] d, input logic [10:0] amt,
                      input logic expErr, input logic [15:0] expBal);
    applyStimulus(term, opc, s, d, amt, expErr, expBal, 1'b1);
    runOp(term);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; op = '0; srcIdx = '0; dstIdx = '0; amount = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetGnt", 32'(gnt), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetErr", 32'(err), 32'd0);
    checkOutput("resetRsp", 32'(rspBalance), 32'd0);
    rst_n = 1'b1;

    doOp(2, OP_BAL, 4'd7, 4'd0, 11'd0, 1'b0, 16'd500);
    doOp(0, OP_WD, 4'd3, 4'd0, 11'd200, 1'b0, 16'd300);
    doOp(0, OP_WD, 4'd3, 4'd0, 11'd301, 1'b1, 16'd300);
    doOp(1, OP_XFER, 4'd1, 4'd2, 11'd1548, 1'b1, 16'd500);
    doOp(1, OP_XFER, 4'd1, 4'd2, 11'd400, 1'b0, 16'd100);
    doOp(3, OP_BAL, 4'd2, 4'd0, 11'd0, 1'b0, 16'd900);

    // Fill acc 5 to 2000, then probe the MAX_BAL ceiling from acc 4.
    doOp(2, OP_XFER, 4'd6, 4'd5, 11'd500, 1'b0, 16'd0);
    doOp(3, OP_XFER, 4'd8, 4'd5, 11'd500, 1'b0, 16'd0);
    doOp(0, OP_XFER, 4'd9, 4'd5, 11'd500, 1'b0, 16'd0);
    doOp(1, OP_BAL, 4'd5, 4'd0, 11'd0, 1'b0, 16'd2000);
    doOp(2, OP_XFER, 4'd4, 4'd5, 11'd48, 1'b1, 16'd500);
    doOp(3, OP_BAL, 4'd5, 4'd0, 11'd0, 1'b0, 16'd2000);
    doOp(0, OP_XFER, 4'd4, 4'd5, 11'd47, 1'b0, 16'd453);
    doOp(1, OP_BAL, 4'd5, 4'd0, 11'd0, 1'b0, 16'd2047);

    doOp(2, OP_BAL, 4'd12, 4'd0, 11'd0, 1'b1, 16'd0);
    doOp(3, OP_XFER, 4'd4, 4'd10, 11'd1, 1'b1, 16'd453);
    doOp(0, OP_RSV, 4'd4, 4'd0, 11'd1, 1'b1, 16'd453);
    doOp(1, OP_XFER, 4'd4, 4'd4, 11'd1, 1'b1, 16'd453);
    doOp(2, OP_WD, 4'd4, 4'd0, 11'd0, 1'b0, 16'd453);
    doOp(3, OP_XFER, 4'd4, 4'd6, 11'd0, 1'b0, 16'd453);
    doOp(0, OP_BAL, 4'd6, 4'd0, 11'd0, 1'b0, 16'd0);

    // Reset lands while the withdraw sits in EXEC: no done pulse and no ledger write.
    applyStimulus(3, OP_WD, 4'd0, 4'd0, 11'd100, 1'b0, 16'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("abortGnt", 32'(gnt), 32'd8);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortGntCleared", 32'(gnt), 32'd0);
    checkOutput("abortDoneLow", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("abortNoDone", 32'(done), 32'd0);
      checkOutput("abortIdleGnt", 32'(gnt), 32'd0);
    end
    doOp(3, OP_BAL, 4'd0, 4'd0, 11'd0, 1'b0, 16'd500);
    doOp(1, OP_BAL, 4'd5, 4'd0, 11'd0, 1'b0, 16'd500);

    // Continuous requests from every terminal: fresh pointer, then strict rotation.
    resetDut();
    for (int t = 0; t < 4; t++) applyStimulus(t, OP_BAL, 4'(t), 4'd0, 11'd0, 1'b0, 16'd500, 1'b0);
    for (int n = 0; n < 5; n++) expQ.push_back('{n % 4, 1'b0, 16'd500});
    for (int cyc = 1; cyc <= 15; cyc++) begin
      int   w;
      exp_t e;
      @(posedge clk); #1;
      w = ((cyc - 1) / 3) % 4;
      checkOutput("rrGnt", 32'(gnt), 32'(1 << w));
      checkOutput("rrDone", 32'(done), (cyc % 3 == 0) ? 32'(1 << w) : 32'd0);
      if (done != '0 && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rrTerm", 32'(done), 32'(1 << e.term));
        checkOutput("rrErr", 32'(err), 32'(e.err));
        checkOutput("rrRsp", 32'(rspBalance), 32'(e.bal));
      end
    end
    req = '0;
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/atm_ledger_arbiter.md
ATM_LEDGER_ARBITER -- requirements
Module: atm_ledger_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of ATM terminals sharing the ledger.
REQ-002 Parameter NUM_ACC, 10, number of ledger accounts (indices 0..NUM_ACC-1).
REQ-003 Parameter INIT_BAL, 500, balance of every account after reset.
REQ-004 Parameter MAX_BAL, 2047, largest balance an account may hold.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_REQ  per-terminal request; bit i belongs to terminal i.
REQ-008 op  input  2*NUM_REQ  per-terminal opcode, slice [2i+1:2i]: 0 BALANCE, 1 WITHDRAW, 2 TRANSFER, 3 reserved.
REQ-009 src_idx  input  4*NUM_REQ  per-terminal source account index, slice [4i+3:4i].
REQ-010 dst_idx  input  4*NUM_REQ  per-terminal destination account index; used by TRANSFER only.
REQ-011 amount  input  11*NUM_REQ  per-terminal amount, unsigned, slice [11i+10:11i].
REQ-012 gnt  output  NUM_REQ  one-hot grant; high while that terminal's operation is in flight.
REQ-013 done  output  NUM_REQ  one-cycle completion pulse to the granted terminal.
REQ-014 err  output  1  operation rejected; valid only in the done cycle.
REQ-015 rsp_balance  output  16  source-account balance after the operation; valid only in the done cycle.

Function
REQ-016 The block SHALL hold a ledger of NUM_ACC 16-bit balances, reachable only through this arbiter.
REQ-017 FSM states: IDLE, EXEC, COMMIT; reset state IDLE.
REQ-018 IDLE: if any req bit is high at a rising edge, the block SHALL pick one winner, latch its op/src/dst/amount, assert gnt[winner], and go to EXEC.
REQ-019 IDLE with req all zero: stay in IDLE, gnt=0.
REQ-020 EXEC: validate the latched command against the current ledger, then go to COMMIT; the ledger is not written in EXEC.
REQ-021 COMMIT: apply the ledger write if valid; pulse done[winner] for exactly one cycle; drive err and rsp_balance; keep gnt[winner]; go to IDLE.
REQ-022 Latency: req sampled at edge k -> gnt high after edge k -> done high after edge k+2 for one cycle -> gnt low after edge k+3.
REQ-023 Peak throughput SHALL be one operation per 3 cycles.
REQ-024 Arbitration SHALL be round-robin: search starts at (last winner + 1) mod NUM_REQ; after reset the pointer makes terminal 0 highest priority.
REQ-025 Command inputs are sampled only at the grant edge; later changes, including req dropping, SHALL NOT affect the in-flight operation.
REQ-026 A terminal that holds req high after its done SHALL be re-arbitrated fairly and is not served again before every other requesting terminal.
REQ-027 BALANCE: no write; err=0 if src_idx < NUM_ACC.
REQ-028 WITHDRAW: valid iff amount <= bal[src]; on success bal[src] -= amount.
REQ-029 TRANSFER: valid iff src != dst, amount <= bal[src], and bal[dst] + amount <= MAX_BAL, with the sum computed at 17 bits and no wrap.
REQ-030 On TRANSFER success: bal[src] -= amount and bal[dst] += amount in the same COMMIT edge.
REQ-031 Any src_idx, or for TRANSFER any dst_idx, >= NUM_ACC, or op=3: err=1 and no ledger change.
REQ-032 Any rejected operation: err=1, ledger unchanged, rsp_balance = current bal[src] (0 if src out of range).
REQ-033 amount=0 is valid for WITHDRAW and TRANSFER, and leaves the balances unchanged.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, gnt=0, done=0, err=0, rsp_balance=0, RR pointer to terminal 0, and every ledger entry to INIT_BAL.
REQ-035 Reset asserted in EXEC or COMMIT SHALL abort the operation with no ledger write and no done pulse.
REQ-036 The first arbitration SHALL occur at the first rising edge with rst_n high.

Verification
REQ-037 Reset, then BALANCE on acc 7 from terminal 2 -> gnt=0100 one edge later; done[2] two edges after that; rsp_balance=500; err=0.
REQ-038 WITHDRAW 200 from acc 3 -> rsp_balance=300, err=0; then WITHDRAW 301 from acc 3 -> err=1, rsp_balance=300.
REQ-039 All four req held high continuously -> grants in order 0,1,2,3,0, each 3 cycles apart, one-hot throughout.
REQ-040 TRANSFER 1548 from acc 1 to acc 2 after reset -> err=1 (amount > 500); TRANSFER 400 from acc 1 to acc 2 -> acc1=100, acc2=900.
REQ-041 Raise acc 5 to 2000, then TRANSFER 48 into acc 5 -> err=1, both balances unchanged; TRANSFER 47 -> acc5=2047.
REQ-042 WITHDRAW 100 from acc 0, with rst_n pulsed low during EXEC -> no done pulse; after reset BALANCE acc 0 returns 500.
